// File: rtl/scaler_tick_gen.sv
// Programmable fast/slow tick generator for scaler gating: one-cycle fast tick every
// div_active_o enabled cycles, slow tick on every SLOW_DIV-th fast tick.
module scaler_tick_gen #(
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned DEFAULT_DIV = 33333,
    parameter int unsigned SLOW_WIDTH  = 10,
    parameter int unsigned SLOW_DIV    = 1000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 sync_i,
    input  logic [CNT_WIDTH-1:0] div_i,
    input  logic                 div_load_i,
    output logic                 tick_o,
    output logic                 slow_tick_o,
    output logic                 div_pending_o,
    output logic [CNT_WIDTH-1:0] div_active_o,
    output logic [CNT_WIDTH-1:0] phase_o
);

    localparam logic [CNT_WIDTH-1:0]  DIV_RST   = CNT_WIDTH'(DEFAULT_DIV);
    localparam logic [CNT_WIDTH-1:0]  DIV_MIN   = CNT_WIDTH'(2);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [SLOW_WIDTH-1:0] SLOW_LAST = SLOW_WIDTH'(SLOW_DIV - 1);
    localparam logic [SLOW_WIDTH-1:0] SLOW_ONE  = SLOW_WIDTH'(1);

    logic [SLOW_WIDTH-1:0] slow_q;
    logic [CNT_WIDTH-1:0]  div_pend_q;   // equals div_active_o whenever nothing is pending
    logic [CNT_WIDTH-1:0]  load_val_c;
    logic [CNT_WIDTH-1:0]  next_div_c;
    logic                  wrap_c;

    // A load coinciding with a boundary bypasses the pending register.
    always_comb begin
        load_val_c = (div_i < DIV_MIN) ? DIV_MIN : div_i;
        next_div_c = div_load_i ? load_val_c : div_pend_q;
        wrap_c     = en_i && (phase_o == (div_active_o - CNT_ONE));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_o       <= '0;
            slow_q        <= '0;
            tick_o        <= 1'b0;
            slow_tick_o   <= 1'b0;
            div_pending_o <= 1'b0;
            div_pend_q    <= DIV_RST;
            div_active_o  <= DIV_RST;
        end else begin
            tick_o      <= 1'b0;
            slow_tick_o <= 1'b0;
            if (sync_i) begin
                phase_o       <= '0;
                slow_q        <= '0;
                div_active_o  <= next_div_c;
                div_pend_q    <= next_div_c;
                div_pending_o <= 1'b0;
            end else if (wrap_c) begin
                phase_o       <= '0;
                tick_o        <= 1'b1;
                div_active_o  <= next_div_c;
                div_pend_q    <= next_div_c;
                div_pending_o <= 1'b0;
                if (slow_q == SLOW_LAST) begin
                    slow_q      <= '0;
                    slow_tick_o <= 1'b1;
                end else begin
                    slow_q <= slow_q + SLOW_ONE;
                end
            end else begin
                if (en_i) begin
                    phase_o <= phase_o + CNT_ONE;
                end
                if (div_load_i) begin
                    div_pend_q    <= load_val_c;
                    div_pending_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_scaler_tick_gen.sv
// Bench for scaler_tick_gen: cycle scoreboard against a behavioural model plus
// directed period/phase checks; a default-parameter instance checks the 33333-cycle tick.
module tb_scaler_tick_gen;

    localparam int unsigned CW = 16;
    localparam int unsigned SD = 3;
    localparam int unsigned DD = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          en_i = 1'b0;
    logic          sync_i = 1'b0;
    logic [CW-1:0] div_i = '0;
    logic          div_load_i = 1'b0;
    logic          tick_o, slow_tick_o, div_pending_o;
    logic [CW-1:0] div_active_o, phase_o;

    logic          rst_d = 1'b1;
    logic          tick_d, slow_tick_d, div_pending_d;
    logic [CW-1:0] div_active_d, phase_d;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic          tick;
        logic          slow;
        logic          pend;
        logic [CW-1:0] act;
        logic [CW-1:0] phase;
    } exp_t;
    exp_t sb_q[$];

    // model state
    int m_cnt = 0, m_slow = 0, m_act = DD, m_pval = DD;
    logic m_pend = 1'b0, m_tick = 1'b0, m_st = 1'b0;

    always #5 clk_i = ~clk_i;

    scaler_tick_gen #(.CNT_WIDTH(CW), .DEFAULT_DIV(DD), .SLOW_WIDTH(10), .SLOW_DIV(SD)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .sync_i(sync_i), .div_i(div_i),
        .div_load_i(div_load_i), .tick_o(tick_o), .slow_tick_o(slow_tick_o),
        .div_pending_o(div_pending_o), .div_active_o(div_active_o), .phase_o(phase_o)
    );

    scaler_tick_gen dut_def (
        .clk_i(clk_i), .rst_i(rst_d), .en_i(1'b1), .sync_i(1'b0), .div_i('0),
        .div_load_i(1'b0), .tick_o(tick_d), .slow_tick_o(slow_tick_d),
        .div_pending_o(div_pending_d), .div_active_o(div_active_d), .phase_o(phase_d)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model(input logic r, input logic e, input logic s, input int d, input logic l);
        int lv;
        logic bnd;
        lv = (d < 2) ? 2 : d;
        m_tick = 1'b0;
        m_st = 1'b0;
        if (r) begin
            m_cnt = 0; m_slow = 0; m_pend = 1'b0; m_pval = DD; m_act = DD;
        end else if (s) begin
            m_cnt = 0; m_slow = 0;
            m_act = l ? lv : (m_pend ? m_pval : m_act);
            m_pval = m_act; m_pend = 1'b0;
        end else begin
            bnd = e && (m_cnt == m_act - 1);
            if (bnd) begin
                m_cnt = 0; m_tick = 1'b1;
                if (m_slow == SD - 1) begin m_slow = 0; m_st = 1'b1; end
                else m_slow++;
                m_act = l ? lv : (m_pend ? m_pval : m_act);
                m_pval = m_act; m_pend = 1'b0;
            end else begin
                if (e) m_cnt++;
                if (l) begin m_pval = lv; m_pend = 1'b1; end
            end
        end
    endtask

    // One clock: drive on negedge, push model expectation, compare after the edge.
    task automatic step(input logic r, input logic e, input logic s, input int d, input logic l);
        exp_t x;
        @(negedge clk_i);
        rst_i = r; en_i = e; sync_i = s; div_i = CW'(d); div_load_i = l;
        model(r, e, s, d, l);
        x.tick = m_tick; x.slow = m_st; x.pend = m_pend;
        x.act = CW'(m_act); x.phase = CW'(m_cnt);
        sb_q.push_back(x);
        @(posedge clk_i);
        #1;
        x = sb_q.pop_front();
        chk("sb_tick", 32'(tick_o), 32'(x.tick));
        chk("sb_slow", 32'(slow_tick_o), 32'(x.slow));
        chk("sb_pend", 32'(div_pending_o), 32'(x.pend));
        chk("sb_act", 32'(div_active_o), 32'(x.act));
        chk("sb_phase", 32'(phase_o), 32'(x.phase));
    endtask

    // Enabled cycles until the next tick; -1 if none within the bound.
    task automatic wait_tick(output int n);
        n = -1;
        for (int i = 1; i <= 50; i++) begin
            step(1'b0, 1'b1, 1'b0, 0, 1'b0);
            if (tick_o) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n, tk;
        logic [15:0] tmask, smask;
        logic [CW-1:0] ph1, ph3, ph4;

        // reset and default cadence
        step(1'b1, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 0, 1'b0);
        chk("rst_tick", 32'(tick_o), 0);
        chk("rst_pend", 32'(div_pending_o), 0);
        chk("rst_act", 32'(div_active_o), DD);
        chk("rst_phase", 32'(phase_o), 0);
        tmask = '0; smask = '0; ph1 = '0; ph3 = '0; ph4 = '0;
        for (int i = 1; i <= 12; i++) begin
            step(1'b0, 1'b1, 1'b0, 0, 1'b0);
            tmask[i] = tick_o;
            smask[i] = slow_tick_o;
            if (i == 1) ph1 = phase_o;
            if (i == 3) ph3 = phase_o;
            if (i == 4) ph4 = phase_o;
        end
        chk("t1_tick_edges", 32'(tmask), 32'h1110);
        chk("t1_slow_edges", 32'(smask), 32'h1000);
        chk("t1_phase1", 32'(ph1), 1);
        chk("t1_phase3", 32'(ph3), 3);
        chk("t1_phase4", 32'(ph4), 0);

        // divisor 6 loaded at phase 1: current period stays 4
        step(1'b0, 1'b1, 1'b0, 0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 6, 1'b1);
        chk("t2_pending", 32'(div_pending_o), 1);
        chk("t2_act_old", 32'(div_active_o), 4);
        wait_tick(n);
        chk("t2_rest_of_old", n, 2);
        chk("t2_pend_clear", 32'(div_pending_o), 0);
        chk("t2_act_new", 32'(div_active_o), 6);
        wait_tick(n); chk("t2_period_a", n, 6);
        wait_tick(n); chk("t2_period_b", n, 6);

        // clamping and last-load-wins
        step(1'b0, 1'b1, 1'b0, 1, 1'b1);
        wait_tick(n);
        chk("t3_clamp1_act", 32'(div_active_o), 2);
        wait_tick(n); chk("t3_clamp1_period", n, 2);
        step(1'b0, 1'b0, 1'b0, 5, 1'b1);
        step(1'b0, 1'b0, 1'b0, 7, 1'b1);
        chk("t3_pend_two", 32'(div_pending_o), 1);
        wait_tick(n);
        chk("t3_last_wins", 32'(div_active_o), 7);
        wait_tick(n); chk("t3_period7", n, 7);
        step(1'b0, 1'b1, 1'b0, 0, 1'b1);
        wait_tick(n);
        chk("t3_clamp0_act", 32'(div_active_o), 2);
        wait_tick(n); chk("t3_clamp0_period", n, 2);
        step(1'b0, 1'b1, 1'b0, 4, 1'b1);
        wait_tick(n);
        wait_tick(n); chk("t3_back_to4", n, 4);

        // enable gap at phase 2
        step(1'b0, 1'b1, 1'b0, 0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 0, 1'b0);
        tk = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0, 0, 1'b0);
            tk += int'(tick_o);
        end
        chk("t4_no_ticks", tk, 0);
        chk("t4_phase_hold", 32'(phase_o), 2);
        wait_tick(n); chk("t4_resume", n, 2);
        wait_tick(n); chk("t4_period", n, 4);

        // resync at phase 3 suppresses the wrap
        step(1'b0, 1'b1, 1'b0, 0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 0, 1'b0);
        chk("t5_phase3", 32'(phase_o), 3);
        step(1'b0, 1'b1, 1'b1, 0, 1'b0);
        chk("t5_sync_tick", 32'(tick_o), 0);
        chk("t5_sync_phase", 32'(phase_o), 0);
        for (int k = 1; k <= 3; k++) begin
            wait_tick(n);
            chk("t5_period", n, 4);
            chk("t5_slow", 32'(slow_tick_o), (k == 3) ? 1 : 0);
        end
        step(1'b0, 1'b1, 1'b0, 0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 5, 1'b1);
        chk("t5_sync_load_act", 32'(div_active_o), 5);
        chk("t5_sync_load_pend", 32'(div_pending_o), 0);
        wait_tick(n); chk("t5_period5", n, 5);
        step(1'b0, 1'b1, 1'b0, 0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 0, 1'b0);
        chk("t5_sync_en_low", 32'(phase_o), 0);

        // reset mid-period discards a pending load
        step(1'b0, 1'b1, 1'b0, 0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 9, 1'b1);
        chk("t6_pend_set", 32'(div_pending_o), 1);
        step(1'b1, 1'b1, 1'b0, 0, 1'b0);
        chk("t6_tick", 32'(tick_o), 0);
        chk("t6_slow", 32'(slow_tick_o), 0);
        chk("t6_pend", 32'(div_pending_o), 0);
        chk("t6_act", 32'(div_active_o), DD);
        chk("t6_phase", 32'(phase_o), 0);
        wait_tick(n); chk("t6_period", n, 4);

        // default parameters: 33333-cycle fast period
        @(negedge clk_i);
        rst_d = 1'b1;
        @(posedge clk_i); #1;
        chk("def_act", 32'(div_active_d), 33333);
        chk("def_phase", 32'(phase_d), 0);
        @(negedge clk_i);
        rst_d = 1'b0;
        n = -1;
        for (int i = 1; i <= 33400; i++) begin
            @(posedge clk_i); #1;
            if (tick_d) begin
                n = i;
                break;
            end
        end
        chk("def_first_tick", n, 33333);
        chk("def_slow", 32'(slow_tick_d), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
